slim_fz_sched: RTL

SLIM_FZ_SCHED -- requirements
Module: slim_fz_sched

---
 rtl/slim_fz_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/slim_fz_sched.sv
// Slime freeze scheduler: one shared collision comparator scans the slimes
// round-robin, and each slime runs an IDLE/FROZEN/THAW/COOL timer FSM driven
// by a prescaled freeze tick.
// Optional feature: define SLIM_FZ_REFREEZE_EN to let a hit during THAW
// refreeze the slime.
module slim_fz_sched #(
    parameter int unsigned N_SLIM     = 4,
    parameter int unsigned TICK_DIV   = 6000000,
    parameter int unsigned FZ_TICKS   = 15,
    parameter int unsigned THAW_TICKS = 3,
    parameter int unsigned CD_TICKS   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                x_blue,
    input  logic [8:0]                y_blue,
    input  logic [10*N_SLIM-1:0]      x_slim_bus,
    input  logic [9*N_SLIM-1:0]       y_slim_bus,
    output logic [N_SLIM-1:0]         frozen,
    output logic [N_SLIM-1:0]         thaw,
    output logic                      hit_valid,
    output logic [$clog2(N_SLIM)-1:0] hit_idx
);

    localparam int unsigned IW   = $clog2(N_SLIM);
    localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MAXT = (FZ_TICKS > CD_TICKS) ? FZ_TICKS : CD_TICKS;
    localparam int unsigned CW   = $clog2(MAXT + 1);

    typedef enum logic [1:0] {StIdle, StFrozen, StThaw, StCool} state_e;

    logic [PW-1:0]     pre_q;
    logic              tick;
    logic [IW-1:0]     scan_q;
    logic [9:0]        xs;
    logic [8:0]        ys;
    logic              collide;
    logic              hit1_q;
    logic [IW-1:0]     idx1_q;
    state_e            state_q [N_SLIM];
    state_e            state_d [N_SLIM];
    logic [CW-1:0]     cnt_q   [N_SLIM];
    logic [CW-1:0]     cnt_d   [N_SLIM];
    logic [N_SLIM-1:0] accept;
    logic [N_SLIM-1:0] frozen_q, thaw_q;
    logic              hit_valid_q;
    logic [IW-1:0]     hit_idx_q;

    assign tick = (pre_q == PW'(TICK_DIV - 1));

    // Freeze-tick prescaler, wraps at TICK_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pre_q <= '0;
        else     pre_q <= tick ? '0 : pre_q + 1'b1;
    end

    // Scan pointer steps one slime per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) scan_q <= '0;
        else     scan_q <= (scan_q == IW'(N_SLIM - 1)) ? '0 : scan_q + 1'b1;
    end

    // Select the scanned slime and run the widened overlap test
    always_comb begin
        xs = '0;
        ys = '0;
        for (int i = 0; i < int'(N_SLIM); i++) begin
            if (scan_q == IW'(i)) begin
                xs = x_slim_bus[10*i +: 10];
                ys = y_slim_bus[9*i +: 9];
            end
        end
        collide = (({1'b0, x_blue} + 11'd24) < ({1'b0, xs} + 11'd62)) &&
                  (({1'b0, x_blue} + 11'd24) > {1'b0, xs}) &&
                  (({1'b0, y_blue} + 10'd41) < ({1'b0, ys} + 10'd2)) &&
                  (({1'b0, y_blue} + 10'd43) > {1'b0, ys});
    end

    // Stage 1: register comparator result with its slime index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit1_q <= 1'b0;
            idx1_q <= '0;
        end else begin
            hit1_q <= collide;
            idx1_q <= scan_q;
        end
    end

    // Stage 2: per-slime next state; a hit outranks a coincident tick
    always_comb begin
        for (int i = 0; i < int'(N_SLIM); i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            accept[i]  = 1'b0;
            case (state_q[i])
                StIdle: begin
                    if (hit1_q && (idx1_q == IW'(i))) begin
                        state_d[i] = StFrozen;
                        cnt_d[i]   = CW'(FZ_TICKS);
                        accept[i]  = 1'b1;
                    end
                end
                StFrozen: begin
                    if (tick) begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                        if (cnt_q[i] == CW'(THAW_TICKS + 1)) state_d[i] = StThaw;
                    end
                end
                StThaw: begin
`ifdef SLIM_FZ_REFREEZE_EN
                    if (hit1_q && (idx1_q == IW'(i))) begin
                        state_d[i] = StFrozen;
                        cnt_d[i]   = CW'(FZ_TICKS);
                        accept[i]  = 1'b1;
                    end else
`endif
                    if (tick) begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                        if (cnt_q[i] == CW'(1)) begin
                            state_d[i] = StCool;
                            cnt_d[i]   = CW'(CD_TICKS);
                        end
                    end
                end
                StCool: begin
                    if (tick) begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                        if (cnt_q[i] == CW'(1)) state_d[i] = StIdle;
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // FSM registers plus registered flag decode and hit report
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_SLIM); i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
            frozen_q    <= '0;
            thaw_q      <= '0;
            hit_valid_q <= 1'b0;
            hit_idx_q   <= '0;
        end else begin
            for (int i = 0; i < int'(N_SLIM); i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                frozen_q[i] <= (state_d[i] == StFrozen) || (state_d[i] == StThaw);
                thaw_q[i]   <= (state_d[i] == StThaw);
            end
            hit_valid_q <= |accept;
            if (|accept) hit_idx_q <= idx1_q;
        end
    end

    assign frozen    = frozen_q;
    assign thaw      = thaw_q;
    assign hit_valid = hit_valid_q;
    assign hit_idx   = hit_idx_q;

endmodule
